// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter with one-deep holding register.
// Optional line-break generation when UART_TX_BREAK_EN is defined.
module uart_tx #(
  parameter int CLOCK_DIVIDER_WIDTH = 8
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
  input  logic                           parity_bit_i,
  input  logic                           parity_even_i,
  input  logic [7:0]                     data_i,
  input  logic                           write_i,
`ifdef UART_TX_BREAK_EN
  input  logic                           break_i,
`endif
  output logic                           ready_o,
  output logic                           busy_o,
  output logic                           serial_o
);

  localparam int W = CLOCK_DIVIDER_WIDTH;
  localparam logic [W-1:0] ONE = W'(1);

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MARK
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;
`endif

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] div_eff;
  logic [2:0]   bit_q, bit_d;
  logic [7:0]   sh_data_q, sh_data_d;
  logic         sh_pen_q, sh_pen_d;
  logic         sh_pev_q, sh_pev_d;
  logic         hold_vld_q, hold_vld_d;
  logic [7:0]   hold_data_q, hold_data_d;
  logic         hold_pen_q, hold_pen_d;
  logic         hold_pev_q, hold_pev_d;
  logic         serial_q, serial_d;
  logic         bit_done;
  logic         load;

  // A divider of zero behaves as one cycle per bit.
  assign div_eff  = (clock_divider_i == '0) ? ONE : clock_divider_i;
  assign bit_done = (cnt_q == div_q - ONE);

  // State and datapath registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= ONE;
      bit_q       <= '0;
      sh_data_q   <= '0;
      sh_pen_q    <= 1'b0;
      sh_pev_q    <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      hold_pen_q  <= 1'b0;
      hold_pev_q  <= 1'b0;
      serial_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sh_data_q   <= sh_data_d;
      sh_pen_q    <= sh_pen_d;
      sh_pev_q    <= sh_pev_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      hold_pen_q  <= hold_pen_d;
      hold_pev_q  <= hold_pev_d;
      serial_q    <= serial_d;
    end
  end

  // Next state, bit timing, shifter load and holding-register writes.
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    div_d       = div_q;
    sh_data_d   = sh_data_q;
    sh_pen_d    = sh_pen_q;
    sh_pev_d    = sh_pev_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    hold_pen_d  = hold_pen_q;
    hold_pev_d  = hold_pev_q;
    load        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_i) state_d = S_BREAK;
        else
`endif
        if (hold_vld_q) state_d = S_START;
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_q == 3'd7) state_d = sh_pen_q ? S_PARITY : S_STOP;
          else bit_d = bit_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (bit_done) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_done) begin
`ifdef UART_TX_BREAK_EN
          if (break_i) state_d = S_BREAK;
          else
`endif
          if (hold_vld_q) state_d = S_START;
          else state_d = S_IDLE;
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        if (!break_i) state_d = S_MARK;
      end
      S_MARK: begin
        if (bit_done) state_d = hold_vld_q ? S_START : S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Frame start: take the buffered byte and freeze the bit period.
    if (state_d == S_START && state_q != S_START) begin
      load       = 1'b1;
      sh_data_d  = hold_data_q;
      sh_pen_d   = hold_pen_q;
      sh_pev_d   = hold_pev_q;
      hold_vld_d = 1'b0;
      div_d      = div_eff;
    end
`ifdef UART_TX_BREAK_EN
    if (state_d == S_BREAK && state_q != S_BREAK) div_d = div_eff;
`endif

    if (write_i && !hold_vld_q) begin
      hold_vld_d  = 1'b1;
      hold_data_d = data_i;
      hold_pen_d  = parity_bit_i;
      hold_pev_d  = parity_even_i;
    end
  end

  // Bit-period counter: restarts on every bit boundary, parked when idle.
  always_comb begin
    cnt_d = cnt_q + ONE;
    if (bit_done || load || state_q == S_IDLE) cnt_d = '0;
`ifdef UART_TX_BREAK_EN
    if (state_q == S_BREAK) cnt_d = '0;
`endif
  end

  // Line level for the state being entered, registered into serial_q.
  always_comb begin
    serial_d = 1'b1;
    unique case (state_d)
      S_IDLE:   serial_d = 1'b1;
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = sh_data_q[bit_d];
      S_PARITY: serial_d = sh_pev_q ? ^sh_data_q : ~^sh_data_q;
      S_STOP:   serial_d = 1'b1;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  serial_d = 1'b0;
      S_MARK:   serial_d = 1'b1;
`endif
      default:  serial_d = 1'b1;
    endcase
  end

  assign ready_o  = ~hold_vld_q;
  assign busy_o   = (state_q != S_IDLE);
  assign serial_o = serial_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: vector table plus directed sequences for uart_tx.
// A line monitor checks every bit cycle against a scoreboard queue.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst, wr, pe, pev;
  logic [7:0] din, ddiv;
  logic       ready, busy, ser;
`ifdef UART_TX_BREAK_EN
  logic       brk;
`endif

  always #5 clk = ~clk;

  uart_tx #(.CLOCK_DIVIDER_WIDTH(8)) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .clock_divider_i(ddiv),
    .parity_bit_i   (pe),
    .parity_even_i  (pev),
    .data_i         (din),
    .write_i        (wr),
`ifdef UART_TX_BREAK_EN
    .break_i        (brk),
`endif
    .ready_o        (ready),
    .busy_o         (busy),
    .serial_o       (ser)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       par;
  } frm_t;
  frm_t sb[$];

  // Line monitor
  int   cur_div = 8;
  bit   mon_rst = 1'b0;
  bit   mon_hold = 1'b0;
  bit   m_act = 1'b0;
  bit   m_junk = 1'b0;
  bit   m_bad;
  int   m_idx, m_cnt, m_n, m_bidx;
  logic m_exp[11];
  logic m_got;
  frm_t m_f;

  always @(negedge clk) begin
    if (mon_rst) begin
      m_act  = 1'b0;
      m_junk = 1'b0;
    end else begin
      if (m_junk && !busy) m_junk = 1'b0;
      if (!m_act && !m_junk && !mon_hold && ser === 1'b0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          m_junk = 1'b1;
          $display("FAIL unexpected_frame: start bit with empty scoreboard, got 1 frame expected 0");
        end else begin
          m_f = sb.pop_front();
          m_exp[0] = 1'b0;
          for (int i = 0; i < 8; i++) m_exp[i+1] = m_f.data[i];
          m_n = 9;
          if (m_f.pe) begin
            m_exp[9] = m_f.par;
            m_n = 10;
          end
          m_exp[m_n] = 1'b1;
          m_n++;
          m_act = 1'b1;
          m_idx = 0;
          m_cnt = 0;
          m_bad = 1'b0;
        end
      end
      if (m_act) begin
        if (ser !== m_exp[m_idx] && !m_bad) begin
          m_bad  = 1'b1;
          m_bidx = m_idx;
          m_got  = ser;
        end
        m_cnt++;
        if (m_cnt == cur_div) begin
          m_cnt = 0;
          m_idx++;
          if (m_idx == m_n) begin
            m_act = 1'b0;
            checks++;
            if (m_bad) begin
              errors++;
              $display("FAIL frame_%02h: bit %0d got %b expected %b", m_f.data, m_bidx, m_got, m_exp[m_bidx]);
            end
          end
        end
      end
    end
  end

  // Length of the most recent busy_o pulse in cycles.
  int brun = 0;
  int blast = 0;
  always @(negedge clk) begin
    if (busy) brun++;
    else begin
      if (brun != 0) blast = brun;
      brun = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic p,
                            input logic pv, input logic epar,
                            input bit expect_tx);
    int t = 0;
    while (!ready && t < 5000) begin
      tick();
      t++;
    end
    if (t >= 5000) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: ready got 0 expected 1");
    end
    din = d;
    pe  = p;
    pev = pv;
    wr  = 1'b1;
    if (expect_tx) sb.push_back('{d, p, epar});
    tick();
    wr = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 20000) begin
      tick();
      t++;
    end
    if (t >= 20000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy got 1 expected 0");
    end
    @(negedge clk);
    #1;
    repeat (2) tick();
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pev;
    logic [7:0] div;
    int         mdiv;
    logic       par;
    int         blen;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    tbl[0] = '{8'h55, 1'b0, 1'b0, 8'd8, 8, 1'b0, 80};
    tbl[1] = '{8'hAA, 1'b1, 1'b1, 8'd8, 8, 1'b0, 88};
    tbl[2] = '{8'h01, 1'b1, 1'b1, 8'd8, 8, 1'b1, 88};
    tbl[3] = '{8'h00, 1'b1, 1'b0, 8'd8, 8, 1'b1, 88};
    tbl[4] = '{8'hFF, 1'b1, 1'b0, 8'd3, 3, 1'b1, 33};
    tbl[5] = '{8'hC3, 1'b1, 1'b1, 8'd1, 1, 1'b0, 11};
    tbl[6] = '{8'h80, 1'b1, 1'b0, 8'd0, 1, 1'b0, 11};
    tbl[7] = '{8'h3C, 1'b0, 1'b1, 8'd5, 5, 1'b0, 50};

    rst  = 1'b1;
    wr   = 1'b0;
    din  = '0;
    pe   = 1'b0;
    pev  = 1'b0;
    ddiv = 8'd8;
`ifdef UART_TX_BREAK_EN
    brk  = 1'b0;
`endif
    repeat (3) tick();
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_serial", 32'(ser), 32'd1);
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // Latency of a write into an idle transmitter.
    ddiv = 8'd2;
    cur_div = 2;
    write_byte(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lat_ready_low", 32'(ready), 32'd0);
    chk("lat_busy_pre", 32'(busy), 32'd0);
    chk("lat_serial_pre", 32'(ser), 32'd1);
    tick();
    chk("lat_serial_start", 32'(ser), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_ready_back", 32'(ready), 32'd1);
    wait_idle();
    chk("lat_busy_len", 32'(blast), 32'd20);

    // Table: single frames; the divider is scrambled mid-frame.
    foreach (tbl[i]) begin
      ddiv = tbl[i].div;
      cur_div = tbl[i].mdiv;
      write_byte(tbl[i].data, tbl[i].pe, tbl[i].pev, tbl[i].par, 1'b1);
      tick();
      ddiv = 8'd13;
      wait_idle();
      chk("vec_busy_len", 32'(blast), 32'(tbl[i].blen));
      chk("vec_ready", 32'(ready), 32'd1);
    end

    // Back-to-back frames with even parity.
    ddiv = 8'd8;
    cur_div = 8;
    write_byte(8'hAA, 1'b1, 1'b1, 1'b0, 1'b1);
    write_byte(8'h01, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_idle();
    chk("b2b_busy_len", 32'(blast), 32'd176);

    // Writes while the holding register is full are dropped.
    write_byte(8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    din = 8'hFF;
    wr = 1'b1;
    tick();
    wr = 1'b0;
    write_byte(8'h11, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("full_ready", 32'(ready), 32'd0);
    din = 8'hFF;
    wr = 1'b1;
    tick();
    wr = 1'b0;
    wait_idle();
    chk("drop_busy_len", 32'(blast), 32'd176);
    chk("drop_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during data bit 3 with a byte buffered.
    write_byte(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    write_byte(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4 * 8 + 1) tick();
    mon_rst = 1'b1;
    rst = 1'b1;
    tick();
    chk("rst_serial", 32'(ser), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    sb.delete();
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (ser !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("rst_no_activity", 32'(lows), 32'd0);
    mon_rst = 1'b0;

`ifdef UART_TX_BREAK_EN
    // Break requested mid-frame, held past the stop bit.
    ddiv = 8'd4;
    cur_div = 4;
    write_byte(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (19) tick();
    brk = 1'b1;
    mon_hold = 1'b1;
    repeat (30) tick();
    chk("brk_serial_low", 32'(ser), 32'd0);
    chk("brk_busy", 32'(busy), 32'd1);
    brk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mark_serial", 32'(ser), 32'd1);
      chk("mark_busy", 32'(busy), 32'd1);
    end
    tick();
    chk("mark_end_busy", 32'(busy), 32'd0);
    chk("mark_end_serial", 32'(ser), 32'd1);
    mon_hold = 1'b0;
`endif

    repeat (5) tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the transmit-side partner of the existing `UartRx` receiver. It accepts a byte over a single-cycle write handshake and buffers one further byte in a holding register. It serialises each byte LSB-first as start, 8 data, optional parity and stop bits, with a runtime-programmable clock divider. Framing and parity selection match `UartRx`, so a `uart_tx` `serial_o` looped into `UartRx` `serial_i` with identical settings must round-trip every byte.

## Interface
Parameters:
- `CLOCK_DIVIDER_WIDTH`, default 8: width of `clock_divider_i`.

Ports:
- `clock_i`  in  1  system clock; all logic on the rising edge.
- `reset_i`  in  1  reset, synchronous, active-high.
- `clock_divider_i`  in  CLOCK_DIVIDER_WIDTH  clock cycles per serial bit (D); 0 treated as 1.
- `parity_bit_i`  in  1  1 = insert a parity bit after data bit 7.
- `parity_even_i`  in  1  1 = even parity, 0 = odd parity; ignored when `parity_bit_i`=0.
- `data_i`  in  8  byte to send.
- `write_i`  in  1  write strobe; captured on an edge where `ready_o`=1.
- `ready_o`  out  1  holding register empty; a write is accepted this cycle.
- `busy_o`  out  1  shifter active: a frame or break is in progress.
- `serial_o`  out  1  TX line, idle high, registered.

## Operation
- Storage: one holding register (byte + parity config) feeds the shift state machine. `ready_o` = holding register empty.
- Write: `write_i`=1 and `ready_o`=1 at an edge captures `data_i`, `parity_bit_i` and `parity_even_i`; `ready_o` falls on that same edge. `write_i` with `ready_o`=0 is ignored; there is no error flag.
- FSM states: IDLE -> START -> DATA(bit 0..7) -> PARITY (only if parity enabled) -> STOP -> IDLE, or -> START directly if the holding register is full.
- On leaving IDLE or STOP toward START, the FSM:
  - moves the holding register into the shifter; `ready_o` rises on the same edge;
  - latches `clock_divider_i` for the whole frame. Mid-frame changes take effect on the next frame.
- Bit values:
  - START = 0.
  - DATA = `data[0]` first.
  - PARITY = ^data for even, ~^data for odd; frame ones count even/odd respectively.
  - STOP = 1, one bit period.
- Bit counter: 0..D-1 per bit, no wrap beyond D-1. Data-bit index is 3 bits, 0..7.
- Reset: `serial_o`=1, `ready_o`=1, `busy_o`=0, FSM=IDLE, holding register empty, counters 0. Reset mid-frame aborts the frame and discards any buffered byte. The line is high on the edge after reset is sampled.

## Timing
- Latency: a write accepted at edge N while IDLE gives `serial_o`=0 and `busy_o`=1 from edge N+1.
- Every bit holds `serial_o` for exactly D cycles.
- Frame length: 10·D cycles without parity, 11·D with parity.
- `busy_o` falls at the end of the stop bit when no byte is buffered.
- Back-to-back: a buffered byte's start bit begins the cycle after the previous stop bit ends. There is no idle gap and `busy_o` stays high.
- A write in the same cycle that the holding register empties into the shifter is not accepted, because `ready_o` was 0 at that edge.

## Configuration
- `UART_TX_BREAK_EN` defined: adds port `break_i` (in, 1).
  - While `break_i`=1 and the FSM is IDLE, or as soon as the current frame's stop bit completes, the FSM enters state BREAK: `serial_o`=0 and `busy_o`=1.
  - After `break_i` falls, the FSM drives `serial_o`=1 for D cycles (mark) before IDLE or a buffered START.
  - Writes into the holding register remain allowed during BREAK.
- `UART_TX_BREAK_EN` undefined: no `break_i` port and no BREAK state. Behaviour is otherwise identical.

## Test plan
- Reset, then idle 20 cycles -> `serial_o`=1, `ready_o`=1, `busy_o`=0 throughout.
- D=8, no parity, write 8'h55 -> 80-cycle frame 0,1,0,1,0,1,0,1,0,1 at 8 cycles per bit; `UartRx` loopback yields `data_o`=8'h55 with `ready_o`=1.
- D=8, even parity, write 8'hAA then 8'h01 back-to-back -> first parity bit 0, second parity bit 1. The second start bit follows the first stop bit with 0 idle cycles; `busy_o` is high for 176 cycles.
- D=8, odd parity, write 8'h00; write 8'hFF while `ready_o`=0 -> parity bit 1; 8'hFF is never transmitted.
- Assert reset during data bit 3 of 8'hC3 -> `serial_o`=1 and `ready_o`=1 next cycle; no further low bits appear.
- With `UART_TX_BREAK_EN`, D=4: hold `break_i` high for 30 cycles mid-frame -> the frame completes, then `serial_o` is low until `break_i` falls, then high for 4 cycles before IDLE.
